// File: rtl/adex_spike_monitor.sv
// AdEx spike-train monitor: inter-spike intervals into a small FIFO,
// windowed firing rate, burst pulse and sticky FIFO overflow flag.
module adex_spike_monitor #(
  parameter int WINDOW_LEN = 1000,
  parameter int ISI_W      = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int BURST_THR  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clear,
  input  logic             spike_in,
  output logic             isi_valid,
  output logic [ISI_W-1:0] isi_data,
  input  logic             isi_ready,
  output logic [7:0]       rate_count,
  output logic             rate_valid,
  output logic             burst_flag,
  output logic             fifo_overflow
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int WW = (WINDOW_LEN > 1) ? $clog2(WINDOW_LEN) : 1;
  localparam logic [WW-1:0] WIN_LAST = WW'(WINDOW_LEN - 1);
  localparam logic [PW:0]   DEPTH_C  = (PW + 1)'(FIFO_DEPTH);

  logic             spike_q, spike_d;
  logic             have_prev_q, have_prev_d;
  logic [ISI_W-1:0] isi_cnt_q, isi_cnt_d;
  logic [ISI_W-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]    wr_q, wr_d;
  logic [PW-1:0]    rd_q, rd_d;
  logic [PW:0]      cnt_q, cnt_d;
  logic             burst_q, burst_d;
  logic             ovf_q, ovf_d;
  logic [WW-1:0]    win_q, win_d;
  logic [7:0]       spk_q, spk_d;
  logic [7:0]       rate_q, rate_d;
  logic             rate_v_q, rate_v_d;

  logic             evt;
  logic             push_req;
  logic             push;
  logic             pop;
  logic             full;
  logic [7:0]       spk_sum;
  logic [ISI_W-1:0] isi_sat;

  assign evt      = en & spike_in & ~spike_q;
  assign push_req = evt & have_prev_q;
  assign full     = (cnt_q == DEPTH_C);
  assign pop      = (cnt_q != '0) & isi_ready;
  // A full FIFO still takes a push when the head leaves the same cycle.
  assign push     = push_req & (~full | pop);
  assign spk_sum  = (spk_q == 8'hFF) ? 8'hFF : spk_q + {7'd0, evt};
  assign isi_sat  = (&isi_cnt_q) ? isi_cnt_q : isi_cnt_q + ISI_W'(1);

  assign isi_valid     = (cnt_q != '0);
  assign isi_data      = isi_valid ? mem_q[rd_q] : '0;
  assign rate_count    = rate_q;
  assign rate_valid    = rate_v_q;
  assign burst_flag    = burst_q;
  assign fifo_overflow = ovf_q;

  always_comb begin
    spike_d     = spike_in;
    have_prev_d = have_prev_q;
    isi_cnt_d   = isi_cnt_q;
    wr_d        = wr_q;
    rd_d        = rd_q;
    cnt_d       = cnt_q;
    burst_d     = 1'b0;
    ovf_d       = ovf_q;
    win_d       = win_q;
    spk_d       = spk_q;
    rate_d      = rate_q;
    rate_v_d    = 1'b0;
    if (clear) begin
      spike_d     = 1'b0;
      have_prev_d = 1'b0;
      isi_cnt_d   = '0;
      wr_d        = '0;
      rd_d        = '0;
      cnt_d       = '0;
      ovf_d       = 1'b0;
      win_d       = '0;
      spk_d       = '0;
      rate_d      = '0;
    end else begin
      if (evt) begin
        have_prev_d = 1'b1;
        isi_cnt_d   = ISI_W'(1);
      end else if (en) begin
        isi_cnt_d = isi_sat;
      end
      if (push) begin
        wr_d    = wr_q + PW'(1);
        burst_d = (32'(isi_cnt_q) < BURST_THR);
      end
      if (push_req & full & ~pop) ovf_d = 1'b1;
      if (pop) rd_d = rd_q + PW'(1);
      unique case (1'b1)
        push & ~pop: cnt_d = cnt_q + (PW + 1)'(1);
        pop & ~push: cnt_d = cnt_q - (PW + 1)'(1);
        default:     cnt_d = cnt_q;
      endcase
      if (en) begin
        if (win_q == WIN_LAST) begin
          rate_d   = spk_sum;
          rate_v_d = 1'b1;
          spk_d    = '0;
          win_d    = '0;
        end else begin
          spk_d = spk_sum;
          win_d = win_q + WW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spike_q     <= 1'b0;
      have_prev_q <= 1'b0;
      isi_cnt_q   <= '0;
      wr_q        <= '0;
      rd_q        <= '0;
      cnt_q       <= '0;
      burst_q     <= 1'b0;
      ovf_q       <= 1'b0;
      win_q       <= '0;
      spk_q       <= '0;
      rate_q      <= '0;
      rate_v_q    <= 1'b0;
    end else begin
      spike_q     <= spike_d;
      have_prev_q <= have_prev_d;
      isi_cnt_q   <= isi_cnt_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      cnt_q       <= cnt_d;
      burst_q     <= burst_d;
      ovf_q       <= ovf_d;
      win_q       <= win_d;
      spk_q       <= spk_d;
      rate_q      <= rate_d;
      rate_v_q    <= rate_v_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_q] <= isi_cnt_q;
    end
  end

endmodule

// File: tb/tb_adex_spike_monitor.sv
// Directed bench for adex_spike_monitor with a 100-cycle rate window.
module tb_adex_spike_monitor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        clear;
  logic        spike_in;
  logic        isi_valid;
  logic [15:0] isi_data;
  logic        isi_ready;
  logic [7:0]  rate_count;
  logic        rate_valid;
  logic        burst_flag;
  logic        fifo_overflow;

  int n_cmp = 0;
  int n_bad = 0;

  adex_spike_monitor #(
    .WINDOW_LEN(100),
    .ISI_W(16),
    .FIFO_DEPTH(4),
    .BURST_THR(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .clear(clear),
    .spike_in(spike_in),
    .isi_valid(isi_valid),
    .isi_data(isi_data),
    .isi_ready(isi_ready),
    .rate_count(rate_count),
    .rate_valid(rate_valid),
    .burst_flag(burst_flag),
    .fifo_overflow(fifo_overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Spike lands k edges after the previous spike edge.
  task automatic next_spike(input int k);
    repeat (k - 1) tick();
    spike_in = 1'b1;
    tick();
    spike_in = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; clear = 1'b0;
    spike_in = 1'b0; isi_ready = 1'b0;
    #23;
    n_cmp++;
    if ({isi_valid, isi_data, rate_count, rate_valid, burst_flag, fifo_overflow} !== 28'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h want 0",
        {isi_valid, isi_data, rate_count, rate_valid, burst_flag, fifo_overflow});
    end
    rst_n = 1'b1;
    #3;
    en = 1'b1;
    tick();
  endtask

  task automatic test_isi_basic();
    next_spike(1);
    next_spike(20);
    next_spike(25);
    n_cmp++;
    if (isi_valid !== 1'b1 || isi_data !== 16'd20) begin
      n_bad++;
      $display("FAIL basic_head: got v=%0b d=%0d want v=1 d=20", isi_valid, isi_data);
    end
    n_cmp++;
    if (fifo_overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_ovf: got %0b want 0", fifo_overflow);
    end
    isi_ready = 1'b1;
    tick();
    n_cmp++;
    if (isi_data !== 16'd25) begin
      n_bad++;
      $display("FAIL basic_second: got %0d want 25", isi_data);
    end
    tick();
    isi_ready = 1'b0;
    n_cmp++;
    if (isi_valid !== 1'b0 || isi_data !== 16'd0) begin
      n_bad++;
      $display("FAIL basic_empty: got v=%0b d=%0d want v=0 d=0", isi_valid, isi_data);
    end
  endtask

  task automatic test_held_spike();
    do_clear();
    spike_in = 1'b1;
    repeat (5) tick();
    spike_in = 1'b0;
    n_cmp++;
    if (isi_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL held_no_push: got valid=%0b want 0", isi_valid);
    end
    repeat (25) tick();
    spike_in = 1'b1;
    tick();
    spike_in = 1'b0;
    n_cmp++;
    if (isi_valid !== 1'b1 || isi_data !== 16'd30) begin
      n_bad++;
      $display("FAIL held_isi: got v=%0b d=%0d want v=1 d=30", isi_valid, isi_data);
    end
    isi_ready = 1'b1;
    tick();
    isi_ready = 1'b0;
  endtask

  task automatic test_overflow();
    do_clear();
    next_spike(1);
    repeat (5) next_spike(40);
    n_cmp++;
    if (fifo_overflow !== 1'b1) begin
      n_bad++;
      $display("FAIL ovf_flag: got %0b want 1", fifo_overflow);
    end
    isi_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (isi_valid !== 1'b1 || isi_data !== 16'd40) begin
        n_bad++;
        $display("FAIL ovf_drain%0d: got v=%0b d=%0d want v=1 d=40", i, isi_valid, isi_data);
      end
      tick();
    end
    isi_ready = 1'b0;
    n_cmp++;
    if (isi_valid !== 1'b0 || isi_data !== 16'd0) begin
      n_bad++;
      $display("FAIL ovf_empty: got v=%0b d=%0d want v=0 d=0", isi_valid, isi_data);
    end
    n_cmp++;
    if (fifo_overflow !== 1'b1) begin
      n_bad++;
      $display("FAIL ovf_sticky: got %0b want 1", fifo_overflow);
    end
  endtask

  task automatic test_rate();
    do_clear();
    isi_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      spike_in = (i % 10 == 0);
      tick();
      n_cmp++;
      if (i == 99 || i == 199) begin
        if (rate_valid !== 1'b1 || rate_count !== 8'd10) begin
          n_bad++;
          $display("FAIL rate_win@%0d: got v=%0b c=%0d want v=1 c=10", i, rate_valid, rate_count);
        end
      end else if (rate_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL rate_idle@%0d: got v=%0b want 0", i, rate_valid);
      end
    end
    spike_in = 1'b0;
    isi_ready = 1'b0;
  endtask

  task automatic test_burst();
    do_clear();
    next_spike(1);
    next_spike(8);
    n_cmp++;
    if (burst_flag !== 1'b1) begin
      n_bad++;
      $display("FAIL burst_8: got %0b want 1", burst_flag);
    end
    tick();
    n_cmp++;
    if (burst_flag !== 1'b0) begin
      n_bad++;
      $display("FAIL burst_pulse_len: got %0b want 0", burst_flag);
    end
    next_spike(19);
    n_cmp++;
    if (burst_flag !== 1'b0) begin
      n_bad++;
      $display("FAIL burst_20: got %0b want 0", burst_flag);
    end
    next_spike(16);
    n_cmp++;
    if (burst_flag !== 1'b0) begin
      n_bad++;
      $display("FAIL burst_16: got %0b want 0", burst_flag);
    end
    next_spike(15);
    n_cmp++;
    if (burst_flag !== 1'b1) begin
      n_bad++;
      $display("FAIL burst_15: got %0b want 1", burst_flag);
    end
    n_cmp++;
    if (isi_data !== 16'd8) begin
      n_bad++;
      $display("FAIL burst_head: got %0d want 8", isi_data);
    end
  endtask

  task automatic test_enable_clear();
    do_clear();
    next_spike(1);
    repeat (9) tick();
    en = 1'b0;
    repeat (50) tick();
    en = 1'b1;
    next_spike(11);
    n_cmp++;
    if (isi_valid !== 1'b1 || isi_data !== 16'd20) begin
      n_bad++;
      $display("FAIL en_isi: got v=%0b d=%0d want v=1 d=20", isi_valid, isi_data);
    end
    en = 1'b0;
    isi_ready = 1'b1;
    tick();
    isi_ready = 1'b0;
    en = 1'b1;
    n_cmp++;
    if (isi_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL en_pop: got valid=%0b want 0", isi_valid);
    end
    next_spike(5);
    repeat (7) tick();
    do_clear();
    n_cmp++;
    if ({isi_valid, rate_count, rate_valid, burst_flag, fifo_overflow} !== 12'd0) begin
      n_bad++;
      $display("FAIL clear_state: got %h want 0",
        {isi_valid, rate_count, rate_valid, burst_flag, fifo_overflow});
    end
    next_spike(3);
    n_cmp++;
    if (isi_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL clear_first: got valid=%0b want 0", isi_valid);
    end
  endtask

  initial begin
    test_reset();
    test_isi_basic();
    test_held_spike();
    test_overflow();
    test_rate();
    test_burst();
    test_enable_clear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
